// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: field/immediate/control decode, 32x32 register
// file with write-through, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [6:0]      opcode,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic            branch,
  output logic            jump,
  output logic            valid_out,
  output logic            illegal_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [6:0]      opcode;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            valid;
    logic            illegal;
  } idex_t;

  logic [6:0] op;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic is_r, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic legal, uses_rs1, uses_rs2;
  logic [31:0] imm32;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] regs [NREG];
  idex_t dec, nxt, q;

  assign op    = instr_in[6:0];
  assign rs1_f = instr_in[19:15];
  assign rs2_f = instr_in[24:20];
  assign rd_f  = instr_in[11:7];

  assign is_r      = (op == OP_R);
  assign is_opimm  = (op == OP_IMM);
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign is_jalr   = (op == OP_JALR);
  assign is_lui    = (op == OP_LUI);
  assign is_auipc  = (op == OP_AUIPC);

  assign legal    = is_r | is_opimm | is_load | is_store | is_branch |
                    is_jal | is_jalr | is_lui | is_auipc;
  assign uses_rs1 = is_r | is_opimm | is_load | is_store | is_branch | is_jalr;
  assign uses_rs2 = is_r | is_store | is_branch;

  always_comb begin
    imm32 = '0;
    if (is_opimm || is_load || is_jalr)
      imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
    else if (is_store)
      imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    else if (is_branch)
      imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm32 = {instr_in[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
  end

  // Array writes land on the edge; same-cycle readers see wb_data through the bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_f != 5'd0) rs1_val = (wb_en && wb_rd == rs1_f) ? wb_data : regs[rs1_f];
    if (rs2_f != 5'd0) rs2_val = (wb_en && wb_rd == rs2_f) ? wb_data : regs[rs2_f];
  end

  assign hazard_stall = ~flush & q.valid & q.mem_read & (q.rd != 5'd0) &
                        (((q.rd == rs1_f) & uses_rs1) | ((q.rd == rs2_f) & uses_rs2));

  always_comb begin
    dec            = '0;
    dec.pc         = pc_in;
    dec.rs1_data   = rs1_val;
    dec.rs2_data   = rs2_val;
    dec.imm        = XLEN'($signed(imm32));
    dec.rs1        = rs1_f;
    dec.rs2        = rs2_f;
    dec.rd         = rd_f;
    dec.funct3     = instr_in[14:12];
    dec.funct7b5   = instr_in[30];
    dec.opcode     = op;
    dec.reg_write  = (is_r | is_opimm | is_load | is_jal | is_jalr | is_lui | is_auipc) &
                     (rd_f != 5'd0);
    dec.mem_read   = is_load;
    dec.mem_write  = is_store;
    dec.mem_to_reg = is_load;
    dec.alu_src    = legal & ~is_r & ~is_branch;
    dec.branch     = is_branch;
    dec.jump       = is_jal | is_jalr;
    dec.valid      = 1'b1;
  end

  // flush > stall > hazard > normal; bubbles are all-zero apart from the illegal flag.
  always_comb begin
    nxt = q;
    if (flush) begin
      nxt = '0;
    end else if (!stall) begin
      if (hazard_stall || !legal) begin
        nxt         = '0;
        nxt.illegal = ~hazard_stall & ~legal & (instr_in != 32'd0);
      end else begin
        nxt = dec;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

  assign pc_out        = q.pc;
  assign rs1_data      = q.rs1_data;
  assign rs2_data      = q.rs2_data;
  assign imm           = q.imm;
  assign rs1           = q.rs1;
  assign rs2           = q.rs2;
  assign rd            = q.rd;
  assign funct3        = q.funct3;
  assign funct7b5      = q.funct7b5;
  assign opcode        = q.opcode;
  assign reg_write     = q.reg_write;
  assign mem_read      = q.mem_read;
  assign mem_write     = q.mem_write;
  assign mem_to_reg    = q.mem_to_reg;
  assign alu_src       = q.alu_src;
  assign branch        = q.branch;
  assign jump          = q.jump;
  assign valid_out     = q.valid;
  assign illegal_instr = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - table-driven scoreboard bench for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, wb_data;
  logic        stall, flush, wb_en;
  logic [4:0]  wb_rd;
  logic        hazard_stall;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [6:0]  opcode;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump;
  logic        valid_out, illegal_instr;

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .pc_out(pc_out), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7b5(funct7b5), .opcode(opcode),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
    .valid_out(valid_out), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
  localparam logic [6:0] C_0  = 7'b0000000;
  localparam logic [6:0] C_I  = 7'b1000100;
  localparam logic [6:0] C_R  = 7'b1000000;
  localparam logic [6:0] C_LD = 7'b1101100;
  localparam logic [6:0] C_ST = 7'b0010100;
  localparam logic [6:0] C_BR = 7'b0000010;
  localparam logic [6:0] C_J  = 7'b1000101;

  typedef struct {
    logic [31:0] pc, instr;
    logic        st, fl, we;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        haz, vld, ill;
    logic [6:0]  ctrl;
    logic [4:0]  rd, rs1;
    logic [31:0] imm, r1d, r2d, pco;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic [31:0] pc, input logic [31:0] instr, input logic st, input logic fl,
    input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
    input logic haz, input logic vld, input logic ill, input logic [6:0] ctrl,
    input logic [4:0] rd_e, input logic [4:0] rs1_e, input logic [31:0] imm_e,
    input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] pco);
    vec_t v;
    v.pc = pc; v.instr = instr; v.st = st; v.fl = fl; v.we = we; v.wrd = wrd;
    v.wdat = wdat; v.haz = haz; v.vld = vld; v.ill = ill; v.ctrl = ctrl;
    v.rd = rd_e; v.rs1 = rs1_e; v.imm = imm_e; v.r1d = r1d; v.r2d = r2d; v.pco = pco;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input int idx);
    vec_t v, e;
    v = vecs[idx];
    @(negedge clk);
    pc_in = v.pc; instr_in = v.instr; stall = v.st; flush = v.fl;
    wb_en = v.we; wb_rd = v.wrd; wb_data = v.wdat;
    #1;
    cmp($sformatf("v%0d hazard_stall", idx), 32'(hazard_stall), 32'(v.haz));
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    cmp($sformatf("v%0d valid_out", idx), 32'(valid_out), 32'(e.vld));
    cmp($sformatf("v%0d illegal_instr", idx), 32'(illegal_instr), 32'(e.ill));
    cmp($sformatf("v%0d ctrl", idx),
        32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}), 32'(e.ctrl));
    cmp($sformatf("v%0d rd", idx), 32'(rd), 32'(e.rd));
    cmp($sformatf("v%0d rs1", idx), 32'(rs1), 32'(e.rs1));
    cmp($sformatf("v%0d imm", idx), imm, e.imm);
    cmp($sformatf("v%0d rs1_data", idx), rs1_data, e.r1d);
    cmp($sformatf("v%0d rs2_data", idx), rs2_data, e.r2d);
    cmp($sformatf("v%0d pc_out", idx), pc_out, e.pco);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          pc     instr          st fl we rd wdata          hz v  il ctrl  rd rs1 imm           r1d           r2d           pc_out
    vecs.push_back(mk(32'h00, 32'h00500093, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_I,  1, 0, 32'd5,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h04, 32'h00210233, 0, 0, 1, 2, 32'hDEADBEEF, 0, 1, 0, C_R,  4, 2, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h04));
    vecs.push_back(mk(32'h08, 32'h00210233, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_R,  4, 2, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h08));
    vecs.push_back(mk(32'h0C, 32'h0000A283, 0, 0, 1, 1, 32'h100,      0, 1, 0, C_LD, 5, 1, 32'd0,        32'h100,      32'h0,        32'h0C));
    vecs.push_back(mk(32'h10, 32'h00528333, 0, 0, 0, 0, 32'h0,        1, 0, 0, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h10, 32'h00528333, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_R,  6, 5, 32'd0,        32'h0,        32'h0,        32'h10));
    vecs.push_back(mk(32'h14, 32'h0000A283, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_LD, 5, 1, 32'd0,        32'h100,      32'h0,        32'h14));
    vecs.push_back(mk(32'h18, 32'h00108333, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_R,  6, 1, 32'd0,        32'h100,      32'h100,      32'h18));
    vecs.push_back(mk(32'h1C, 32'h0000A283, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_LD, 5, 1, 32'd0,        32'h100,      32'h0,        32'h1C));
    vecs.push_back(mk(32'h20, 32'h00528333, 0, 1, 0, 0, 32'h0,        0, 0, 0, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h20, 32'hFE000EE3, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_BR, 29, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h20));
    vecs.push_back(mk(32'h20, 32'hFE000EE3, 0, 1, 0, 0, 32'h0,        0, 0, 0, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h24, 32'h008000EF, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_J,  1, 0, 32'd8,        32'h0,        32'h0,        32'h24));
    vecs.push_back(mk(32'h28, 32'h00210233, 1, 0, 0, 0, 32'h0,        0, 1, 0, C_J,  1, 0, 32'd8,        32'h0,        32'h0,        32'h24));
    vecs.push_back(mk(32'h2C, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,        0, 1, 0, C_J,  1, 0, 32'd8,        32'h0,        32'h0,        32'h24));
    vecs.push_back(mk(32'h30, 32'h0000A283, 1, 0, 0, 0, 32'h0,        0, 1, 0, C_J,  1, 0, 32'd8,        32'h0,        32'h0,        32'h24));
    vecs.push_back(mk(32'h34, 32'h00500093, 1, 1, 0, 0, 32'h0,        0, 0, 0, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h38, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        0, 0, 1, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h3C, 32'h00000000, 0, 0, 0, 0, 32'h0,        0, 0, 0, C_0,  0, 0, 32'd0,        32'h0,        32'h0,        32'h00));
    vecs.push_back(mk(32'h40, 32'h123454B7, 0, 0, 1, 3, 32'h1234,     0, 1, 0, C_I,  9, 8, 32'h12345000, 32'h0,        32'h1234,     32'h40));
    vecs.push_back(mk(32'h44, 32'h00302223, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_ST, 4, 0, 32'd4,        32'h0,        32'h1234,     32'h44));
    // after the mid-stream reset: x3 is gone, x0 ignores writes
    vecs.push_back(mk(32'h48, 32'h00302223, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_ST, 4, 0, 32'd4,        32'h0,        32'h0,        32'h48));
    vecs.push_back(mk(32'h4C, 32'h00000233, 0, 0, 1, 0, 32'd7,        0, 1, 0, C_R,  4, 0, 32'd0,        32'h0,        32'h0,        32'h4C));
    vecs.push_back(mk(32'h50, 32'h00000233, 0, 0, 0, 0, 32'h0,        0, 1, 0, C_R,  4, 0, 32'd0,        32'h0,        32'h0,        32'h50));

    reset = 1'b1; pc_in = '0; instr_in = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #12;
    n_vec++;
    cmp("reset valid_out", 32'(valid_out), 32'd0);
    cmp("reset ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}), 32'd0);
    cmp("reset illegal_instr", 32'(illegal_instr), 32'd0);
    cmp("reset pc_out", pc_out, 32'h0);
    cmp("reset imm", imm, 32'h0);
    cmp("reset hazard_stall", 32'(hazard_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i <= 20; i++) run(i);

    // asynchronous reset between edges while a valid store sits in ID/EX
    @(negedge clk);
    wb_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_vec++;
    cmp("async reset valid_out", 32'(valid_out), 32'd0);
    cmp("async reset mem_write", 32'(mem_write), 32'd0);
    cmp("async reset pc_out", pc_out, 32'h0);
    cmp("async reset rs2_data", rs2_data, 32'h0);
    cmp("async reset imm", imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 21; i < vecs.size(); i++) run(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
